mem_slot_sequencer: RTL and testbench

Parametrised memory bus-slot sequencer for the Mac core. It generates the per-bus-cycle phase counter and alternates CPU and DMA bus cycles. DMA cycles are arbitrated among N DMA channels (video, sound, refresh, …) by fixed or round-robin priority, and an idle DMA slot is lent to a pending CPU RAM/ROM access. It also produces the CPU /DTACK and per-channel DMA acknowledge pulses. It sits between the clock-enable generator, address decoder and SDRAM glue, replacing hard-wired two-owner slot logic.

---
 rtl/mem_slot_sequencer.sv | 108 ++++++++++
 tb/tb_mem_slot_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slot_sequencer.sv
// mem_slot_sequencer: alternates CPU and DMA memory bus slots, arbitrates DMA channels, lends idle DMA slots to the CPU, and generates /DTACK and DMA acks
// Ports:
//   clk_i          system clock, all state on rising edge
//   rst_ni         system reset (_systemReset), asynchronous, active low
//   clk_en_i       bus-tick enable; the phase advances only when high
//   cpu_as_n_i     CPU address strobe, active low
//   cpu_sel_mem_i  decoded RAM/ROM select
//   cpu_sel_slow_i decoded VPA-style peripheral (never gets /DTACK here)
//   dma_req_i      per-channel DMA request, held until its dma_ack
//   bus_phase_o    current phase of the bus cycle
//   cycle_ready_o  high in the last phase of the bus cycle
//   cpu_slot_o     current cycle is a CPU-owned slot
//   grant_cpu_o    CPU owns memory this cycle (CPU slot or stolen idle DMA slot)
//   grant_dma_o    one-hot DMA owner of the current cycle, zero if none
//   dma_ack_o      one-clk pulse for the granted channel on the final tick
//   cpu_dtack_n_o  CPU data acknowledge, active low
module mem_slot_sequencer #(
  parameter int PHASE_BITS  = 3,
  parameter int DMA_CH      = 3,
  parameter int RR_MODE     = 0,
  parameter int LATCH_PHASE = 2,
  parameter int DONE_PHASE  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clk_en_i,
  input  logic                  cpu_as_n_i,
  input  logic                  cpu_sel_mem_i,
  input  logic                  cpu_sel_slow_i,
  input  logic [DMA_CH-1:0]     dma_req_i,
  output logic [PHASE_BITS-1:0] bus_phase_o,
  output logic                  cycle_ready_o,
  output logic                  cpu_slot_o,
  output logic                  grant_cpu_o,
  output logic [DMA_CH-1:0]     grant_dma_o,
  output logic [DMA_CH-1:0]     dma_ack_o,
  output logic                  cpu_dtack_n_o
);
  localparam int LW = DMA_CH > 1 ? $clog2(DMA_CH) : 1;
  localparam logic [PHASE_BITS-1:0] PH_LAST  = '1;
  localparam logic [PHASE_BITS-1:0] PH_LATCH = PHASE_BITS'(LATCH_PHASE);
  localparam logic [PHASE_BITS-1:0] PH_DONE  = PHASE_BITS'(DONE_PHASE);
  localparam logic [LW-1:0]         LAST_RST = LW'(DMA_CH - 1);
  typedef enum logic {SLOT_CPU, SLOT_DMA} slot_e;
  slot_e                  slot_q, slot_d;
  logic [PHASE_BITS-1:0]  phase_q, phase_d;
  logic [DMA_CH-1:0]      grant_q, grant_d;
  logic [LW-1:0]          last_q, last_d;
  logic                   as_lat_q, as_lat_d;
  logic [DMA_CH-1:0]      win;
  logic [LW-1:0]          win_idx;
  logic                   found;
  logic                   wrap;
  logic                   steal;
  int                     idx;
  // Arbitration search: fixed priority scans from ch0, round-robin from last_grant+1
  always_comb begin
    win = '0;
    win_idx = last_q;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < DMA_CH; k++) begin
      idx = RR_MODE != 0 ? (int'(last_q) + 1 + k) % DMA_CH : k;
      if (!found && dma_req_i[idx]) begin
        found = 1'b1;
        win[idx] = 1'b1;
        win_idx = LW'(idx);
      end
    end
  end
  assign wrap = clk_en_i & cycle_ready_o;
  always_comb begin
    phase_d = clk_en_i ? phase_q + 1'b1 : phase_q;
    slot_d = wrap ? (slot_q == SLOT_CPU ? SLOT_DMA : SLOT_CPU) : slot_q;
    // Entering a DMA slot stores the winner; entering a CPU slot drops the grant
    grant_d = wrap ? (slot_q == SLOT_CPU ? win : '0) : grant_q;
    last_d = (wrap && slot_q == SLOT_CPU && found) ? win_idx : last_q;
    // /AS is sampled once per cycle; it is only forgotten at the cycle end if /AS has gone away
    as_lat_d = !clk_en_i ? as_lat_q :
               phase_q == PH_LATCH ? (~cpu_as_n_i & cpu_sel_mem_i) :
               (cycle_ready_o && cpu_as_n_i) ? 1'b0 : as_lat_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q  <= '0;
      slot_q   <= SLOT_CPU;
      grant_q  <= '0;
      last_q   <= LAST_RST;
      as_lat_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      slot_q   <= slot_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      as_lat_q <= as_lat_d;
    end
  end
  assign bus_phase_o   = phase_q;
  assign cycle_ready_o = phase_q == PH_LAST;
  assign cpu_slot_o    = slot_q == SLOT_CPU;
  assign steal         = slot_q == SLOT_DMA && grant_q == '0 && as_lat_q;
  assign grant_cpu_o   = cpu_slot_o | steal;
  assign grant_dma_o   = grant_q;
  // Ack is gated by the tick so a frozen bus never emits it; reset clears grant_q so no ack follows
  assign dma_ack_o     = grant_q & {DMA_CH{wrap}};
  assign cpu_dtack_n_o = ~((~cpu_as_n_i & as_lat_q & cpu_sel_mem_i & grant_cpu_o & (phase_q >= PH_DONE)) |
                           (~cpu_as_n_i & ~cpu_sel_mem_i & ~cpu_sel_slow_i));
endmodule

// File: tb/tb_mem_slot_sequencer.sv
// tb_mem_slot_sequencer: scoreboard bench for the fixed-priority and round-robin slot sequencer
module tb_mem_slot_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b1;
  logic as_n = 1'b1;
  logic sel_mem = 1'b0;
  logic sel_slow = 1'b0;
  logic [2:0] dma_req = 3'b000;
  logic [2:0] bus_phase, r_bus_phase;
  logic cycle_ready, r_cycle_ready, cpu_slot, r_cpu_slot, grant_cpu, r_grant_cpu, dtack_n, r_dtack_n;
  logic [2:0] grant_dma, r_grant_dma, dma_ack, r_dma_ack;
  logic [2:0] m_phase = 3'd0;
  logic m_par = 1'b0;
  int checks = 0;
  int passes = 0;
  mem_slot_sequencer #(.RR_MODE(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .cpu_as_n_i(as_n),
    .cpu_sel_mem_i(sel_mem), .cpu_sel_slow_i(sel_slow), .dma_req_i(dma_req),
    .bus_phase_o(bus_phase), .cycle_ready_o(cycle_ready), .cpu_slot_o(cpu_slot),
    .grant_cpu_o(grant_cpu), .grant_dma_o(grant_dma), .dma_ack_o(dma_ack), .cpu_dtack_n_o(dtack_n)
  );
  mem_slot_sequencer #(.RR_MODE(1)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .clk_en_i(clk_en), .cpu_as_n_i(as_n),
    .cpu_sel_mem_i(sel_mem), .cpu_sel_slow_i(sel_slow), .dma_req_i(dma_req),
    .bus_phase_o(r_bus_phase), .cycle_ready_o(r_cycle_ready), .cpu_slot_o(r_cpu_slot),
    .grant_cpu_o(r_grant_cpu), .grant_dma_o(r_grant_dma), .dma_ack_o(r_dma_ack), .cpu_dtack_n_o(r_dtack_n)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    if (clk_en) begin
      m_phase = m_phase + 3'd1;
      if (m_phase == 3'd0) m_par = ~m_par;
    end
    #1;
  endtask
  task automatic goto(input logic [2:0] ph, input logic par);
    int n = 0;
    while (!(m_phase == ph && m_par == par) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      $display("FAIL goto phase %0d parity %0d not reached", ph, par);
      $fatal(1, "goto");
    end
  endtask
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (int'(last) + k) % 3;
      if (req[c]) return 2'(c);
    end
    return last;
  endfunction
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus_phase !== 3'd0) $display("FAIL reset_phase got %0d want 0", bus_phase); else passes++;
    checks++; if (cpu_slot !== 1'b1) $display("FAIL reset_cpu_slot got %b want 1", cpu_slot); else passes++;
    checks++; if (grant_dma !== 3'b000) $display("FAIL reset_grant got %b want 000", grant_dma); else passes++;
    checks++; if (dma_ack !== 3'b000) $display("FAIL reset_ack got %b want 000", dma_ack); else passes++;
    checks++; if (dtack_n !== 1'b1) $display("FAIL reset_dtack got %b want 1", dtack_n); else passes++;
    rst_n = 1'b1;
    m_phase = 3'd0;
    m_par = 1'b0;
  endtask
  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (bus_phase !== m_phase) $display("FAIL idle_phase got %0d want %0d", bus_phase, m_phase); else passes++;
      checks++; if (cpu_slot !== ~m_par) $display("FAIL idle_cpu_slot got %b want %b", cpu_slot, ~m_par); else passes++;
      checks++; if (cycle_ready !== (m_phase == 3'd7)) $display("FAIL idle_ready got %b at phase %0d", cycle_ready, m_phase); else passes++;
      checks++; if (grant_dma !== 3'b000) $display("FAIL idle_grant got %b want 000", grant_dma); else passes++;
      checks++; if (dtack_n !== 1'b1) $display("FAIL idle_dtack got %b want 1", dtack_n); else passes++;
    end
  endtask
  task automatic test_rr();
    logic [2:0] q[$];
    logic [2:0] exp;
    logic [1:0] r_last = 2'd2;
    int acks = 0;
    dma_req = 3'b111;
    for (int i = 0; i < 80 && acks < 4; i++) begin
      step();
      if (m_phase == 3'd0 && m_par) begin
        r_last = rr_pick(r_last, 3'b111);
        q.push_back(3'b001 << r_last);
        checks++; if (r_grant_dma !== (3'b001 << r_last)) $display("FAIL rr_grant got %b want %b", r_grant_dma, 3'b001 << r_last); else passes++;
        checks++; if (grant_dma !== 3'b001) $display("FAIL fixed_all_grant got %b want 001", grant_dma); else passes++;
      end
      if (m_phase == 3'd7 && m_par && q.size() > 0) begin
        exp = q.pop_front();
        acks++;
        checks++; if (r_dma_ack !== exp) $display("FAIL rr_ack got %b want %b", r_dma_ack, exp); else passes++;
      end else begin
        checks++; if (r_dma_ack !== 3'b000) $display("FAIL rr_ack_idle got %b want 000 at phase %0d", r_dma_ack, m_phase); else passes++;
      end
    end
    checks++; if (acks != 4) $display("FAIL rr_ack_count got %0d want 4", acks); else passes++;
  endtask
  task automatic test_fixed();
    logic [2:0] q[$];
    logic [2:0] exp;
    int acks = 0;
    bit froze = 0;
    dma_req = 3'b110;
    for (int i = 0; i < 80 && acks < 3; i++) begin
      step();
      if (m_phase == 3'd0 && m_par) begin
        q.push_back(3'b010);
        checks++; if (grant_dma !== 3'b010) $display("FAIL fixed_grant got %b want 010", grant_dma); else passes++;
      end
      if (m_phase == 3'd7 && m_par && q.size() > 0) begin
        if (!froze) begin
          froze = 1;
          clk_en = 1'b0;
          #1;
          checks++; if (dma_ack !== 3'b000) $display("FAIL freeze_ack got %b want 000", dma_ack); else passes++;
          step();
          checks++; if (bus_phase !== 3'd7) $display("FAIL freeze_phase got %0d want 7", bus_phase); else passes++;
          checks++; if (grant_dma !== 3'b010) $display("FAIL freeze_grant got %b want 010", grant_dma); else passes++;
          clk_en = 1'b1;
          #1;
        end
        exp = q.pop_front();
        acks++;
        checks++; if (dma_ack !== exp) $display("FAIL fixed_ack got %b want %b", dma_ack, exp); else passes++;
      end else begin
        checks++; if (dma_ack !== 3'b000) $display("FAIL fixed_ack_idle got %b want 000 at phase %0d", dma_ack, m_phase); else passes++;
      end
    end
    checks++; if (acks != 3) $display("FAIL fixed_ack_count got %0d want 3", acks); else passes++;
  endtask
  task automatic test_cpu();
    int n = 0;
    dma_req = 3'b000;
    goto(3'd1, 1'b0);
    as_n = 1'b0;
    sel_mem = 1'b1;
    for (int p = 2; p <= 5; p++) begin
      step();
      checks++; if (dtack_n !== (m_phase < 3'd4)) $display("FAIL cpu_dtack got %b at phase %0d", dtack_n, m_phase); else passes++;
      checks++; if (grant_cpu !== 1'b1) $display("FAIL cpu_grant got %b want 1", grant_cpu); else passes++;
    end
    as_n = 1'b1;
    #1;
    checks++; if (dtack_n !== 1'b1) $display("FAIL cpu_dtack_release got %b want 1", dtack_n); else passes++;
    dma_req = 3'b001;
    goto(3'd3, 1'b0);
    as_n = 1'b0;
    while (dtack_n !== 1'b0 && n < 24) begin
      step();
      n++;
      if (m_phase == 3'd4 && m_par) begin
        checks++; if (grant_cpu !== 1'b0) $display("FAIL late_busy_grant_cpu got %b want 0", grant_cpu); else passes++;
        checks++; if (grant_dma !== 3'b001) $display("FAIL late_busy_grant_dma got %b want 001", grant_dma); else passes++;
      end
    end
    checks++; if (n != 17) $display("FAIL late_as_latency got %0d ticks want 17", n); else passes++;
    checks++; if (bus_phase !== 3'd4 || cpu_slot !== 1'b1) $display("FAIL late_as_slot got phase %0d cpu_slot %b want 4/1", bus_phase, cpu_slot); else passes++;
    as_n = 1'b1;
    dma_req = 3'b000;
  endtask
  task automatic test_steal();
    goto(3'd1, 1'b1);
    as_n = 1'b0;
    sel_mem = 1'b1;
    step();
    checks++; if (grant_cpu !== 1'b0) $display("FAIL steal_pre_grant got %b want 0", grant_cpu); else passes++;
    step();
    checks++; if (grant_cpu !== 1'b1) $display("FAIL steal_grant got %b want 1", grant_cpu); else passes++;
    checks++; if (dtack_n !== 1'b1) $display("FAIL steal_early_dtack got %b want 1", dtack_n); else passes++;
    step();
    checks++; if (dtack_n !== 1'b0) $display("FAIL steal_dtack got %b want 0", dtack_n); else passes++;
    checks++; if (cpu_slot !== 1'b0 || grant_dma !== 3'b000) $display("FAIL steal_slot got cpu_slot %b grant %b want 0/000", cpu_slot, grant_dma); else passes++;
    as_n = 1'b1;
  endtask
  task automatic test_reset_mid();
    dma_req = 3'b100;
    goto(3'd0, 1'b0);
    goto(3'd5, 1'b1);
    checks++; if (grant_dma !== 3'b100) $display("FAIL mid_grant got %b want 100", grant_dma); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_phase !== 3'd0 || cpu_slot !== 1'b1) $display("FAIL mid_reset_phase got %0d/%b want 0/1", bus_phase, cpu_slot); else passes++;
    checks++; if (grant_dma !== 3'b000 || r_grant_dma !== 3'b000) $display("FAIL mid_reset_grant got %b/%b want 000", grant_dma, r_grant_dma); else passes++;
    dma_req = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++; if (dma_ack !== 3'b000) $display("FAIL mid_reset_ack got %b want 000", dma_ack); else passes++;
    end
    rst_n = 1'b1;
    m_phase = 3'd0;
    m_par = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (dma_ack !== 3'b000 || bus_phase !== m_phase) $display("FAIL post_reset got ack %b phase %0d want 000/%0d", dma_ack, bus_phase, m_phase); else passes++;
    end
    as_n = 1'b0;
    sel_mem = 1'b0;
    sel_slow = 1'b0;
    #1;
    checks++; if (dtack_n !== 1'b0) $display("FAIL fast_dtack got %b want 0", dtack_n); else passes++;
    sel_slow = 1'b1;
    #1;
    checks++; if (dtack_n !== 1'b1) $display("FAIL slow_dtack got %b want 1", dtack_n); else passes++;
    as_n = 1'b1;
    sel_slow = 1'b0;
  endtask
  initial begin
    test_reset();
    test_idle();
    test_rr();
    test_fixed();
    test_cpu();
    test_steal();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
